// File: rtl/lm96570_cfg_seq_if.sv
// Bus bundle between the host / serial writer and the LM96570 config sequencer.
// The slave modport is the sequencer's view; the master modport is the
// view of whoever drives host writes and the serial-writer handshake.
interface lm96570_cfg_seq_if #(
  parameter int DEPTH = 16
) ();
  // Host write side
  logic                    wr_en;
  logic [4:0]              wr_addr;
  logic [63:0]             wr_data;
  logic                    wr_err;
  logic                    full;
  logic [$clog2(DEPTH):0]  level;
  logic                    fire_req;
  // Serial writer side
  logic                    cfg_valid;
  logic [4:0]              cfg_addr;
  logic [63:0]             cfg_data;
  logic [6:0]              cfg_len;
  logic                    cfg_ready;
  logic                    cfg_done;
  logic                    busy;
  logic                    tx_en_req;

  modport slave (
    input  wr_en, wr_addr, wr_data, fire_req, cfg_ready, cfg_done,
    output wr_err, full, level, cfg_valid, cfg_addr, cfg_data, cfg_len,
           busy, tx_en_req
  );

  modport master (
    output wr_en, wr_addr, wr_data, fire_req, cfg_ready, cfg_done,
    input  wr_err, full, level, cfg_valid, cfg_addr, cfg_data, cfg_len,
           busy, tx_en_req
  );
endinterface

// File: rtl/lm96570_cfg_seq.sv
// LM96570 configuration write sequencer.
// Queues host register writes, tags each with its serial frame length and
// hands them one at a time to the serial writer; a latched fire request is
// serviced only once the queue has fully drained.
module lm96570_cfg_seq #(
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  lm96570_cfg_seq_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 5 + 64 + 7;

  // ST_LOAD is the cycle the popped head settles in the output registers,
  // so cfg_valid rises one cycle after the pop.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PRESENT   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FIRE      = 3'd4
  } state_t;

  // Serial data length per register address; 0 marks an invalid address.
  function automatic logic [6:0] frame_len(input logic [4:0] addr);
    logic [6:0] len;
    if (addr <= 5'h07) begin
      len = 7'd22;
    end else if (addr <= 5'h19) begin
      len = 7'd64;
    end else if (addr == 5'h1A) begin
      len = 7'd14;
    end else begin
      len = 7'd0;
    end
    return len;
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [LW-1:0]   level_next_s;
  logic            full_r;
  logic            wr_err_r;
  logic            fire_pend_r;
  logic            cfg_valid_r;
  logic [4:0]      cfg_addr_r;
  logic [63:0]     cfg_data_r;
  logic [6:0]      cfg_len_r;
  logic            busy_r;
  logic            tx_en_req_r;
  logic [6:0]      len_s;
  logic            push_s;
  logic            reject_s;
  logic            pop_s;
  logic            fire_clr_s;

  // Decode the incoming write and decide accept/reject from pre-edge fullness.
  always_comb begin
    len_s    = frame_len(bus.wr_addr);
    push_s   = bus.wr_en & ~full_r & (len_s != 7'd0);
    reject_s = bus.wr_en & ~push_s;
  end

  // Sequencer next state, head pop and fire-pending clear.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    fire_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (level_r != LW'(0)) begin
          pop_s        = 1'b1;
          next_state_s = ST_LOAD;
        end else if (fire_pend_r) begin
          next_state_s = ST_FIRE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        next_state_s = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.cfg_ready) begin
          next_state_s = ST_WAIT_DONE;
        end else begin
          next_state_s = ST_PRESENT;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.cfg_done) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT_DONE;
        end
      end
      ST_FIRE: begin
        fire_clr_s   = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this edge's push/pop; a pop only happens when non-empty.
  always_comb begin
    if (push_s && !pop_s) begin
      level_next_s = level_r + LW'(1);
    end else if (!push_s && pop_s) begin
      level_next_s = level_r - LW'(1);
    end else begin
      level_next_s = level_r;
    end
  end

  // FIFO storage: {addr, data, len} written at the tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= {bus.wr_addr, bus.wr_data, len_s};
    end
  end

  // State, pointers, flags and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      level_r     <= LW'(0);
      full_r      <= 1'b0;
      wr_err_r    <= 1'b0;
      fire_pend_r <= 1'b0;
      cfg_valid_r <= 1'b0;
      cfg_addr_r  <= 5'd0;
      cfg_data_r  <= 64'd0;
      cfg_len_r   <= 7'd0;
      busy_r      <= 1'b0;
      tx_en_req_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      level_r  <= level_next_s;
      full_r   <= (level_next_s == LW'(DEPTH));
      wr_err_r <= reject_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        {cfg_addr_r, cfg_data_r, cfg_len_r} <= mem[rd_ptr_r];
      end
      // Requests arriving while already pending (or while firing) merge.
      if (fire_clr_s) begin
        fire_pend_r <= 1'b0;
      end else if (bus.fire_req) begin
        fire_pend_r <= 1'b1;
      end
      cfg_valid_r <= (next_state_s == ST_PRESENT);
      tx_en_req_r <= (next_state_s == ST_FIRE);
      busy_r      <= (level_next_s != LW'(0)) ||
                     (next_state_s == ST_LOAD) ||
                     (next_state_s == ST_PRESENT) ||
                     (next_state_s == ST_WAIT_DONE);
    end
  end

  assign bus.wr_err    = wr_err_r;
  assign bus.full      = full_r;
  assign bus.level     = level_r;
  assign bus.cfg_valid = cfg_valid_r;
  assign bus.cfg_addr  = cfg_addr_r;
  assign bus.cfg_data  = cfg_data_r;
  assign bus.cfg_len   = cfg_len_r;
  assign bus.busy      = busy_r;
  assign bus.tx_en_req = tx_en_req_r;

endmodule
